// File: rtl/meta_read_arbiter.sv
// meta_read_arbiter
//   Shares the single metadata-array read port of the L1 data cache among
//   NREQ requesters (0 = probe unit, 1 = MSHR file, 2 = LSU replay).
//   Requesters are served in fixed priority by index. A requester that has
//   waited STARVE_LIMIT cycles is boosted above the fixed order. Each
//   accepted read is followed through a LAT-deep shadow pipeline, so the
//   array's response valid can be steered back to the requester that issued it.
//
// Ports
//   clock, reset        clock; asynchronous active-high reset
//   req_valid/req_ready per-requester read handshake
//   req_idx/req_tag     packed per-requester set index and tag
//   arr_valid/arr_ready read request to / accept from the metadata array
//   arr_idx/arr_tag     index and tag of the granted request (0 when idle)
//   resp_valid          one-hot; array output is valid for requester i
//   busy                at least one read is in flight
module meta_read_arbiter #(
    parameter int NREQ         = 3,
    parameter int IDX_W        = 6,
    parameter int TAG_W        = 20,
    parameter int LAT          = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*IDX_W-1:0]   req_idx,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    output logic                    arr_valid,
    input  logic                    arr_ready,
    output logic [IDX_W-1:0]        arr_idx,
    output logic [TAG_W-1:0]        arr_tag,
    output logic [NREQ-1:0]         resp_valid,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = 8;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]   cnt_reg [NREQ];
    logic [NREQ-1:0] boosted;
    logic            boost_any;
    logic [IDW-1:0]  winner_id;
    logic            fire_any;

    logic [LAT-1:0]           stage_v_reg;
    logic [LAT-1:0][IDW-1:0]  stage_id_reg;

    genvar gi;

    // A requester is boosted once it has been denied STARVE_LIMIT cycles.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_boost
            assign boosted[gi] = req_valid[gi] && (cnt_reg[gi] == LIMIT);
        end
    endgenerate

    assign boost_any = |boosted;

    // Scan from the top so the lowest qualifying index is assigned last.
    // When any requester is boosted, only boosted requesters qualify.
    always_comb begin
        winner_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (boost_any ? boosted[i] : req_valid[i]) begin
                winner_id = IDW'(i);
            end
        end
    end

    // Outputs are forced quiet while reset is held.
    assign arr_valid = (|req_valid) && !reset;
    assign fire_any  = arr_valid && arr_ready;
    assign arr_idx   = arr_valid ? req_idx[int'(winner_id)*IDX_W +: IDX_W] : '0;
    assign arr_tag   = arr_valid ? req_tag[int'(winner_id)*TAG_W +: TAG_W] : '0;

    // The winner is always a valid requester, so ready doubles as fire.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = fire_any && (winner_id == IDW'(gi));
        end
    endgenerate

    // Starvation counters. Array back-pressure is not a denial, so counters
    // only advance while arr_ready is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    cnt_reg[i] <= '0;
                end else if (!req_valid[i]) begin
                    cnt_reg[i] <= '0;
                end else if (arr_ready && (cnt_reg[i] < LIMIT)) begin
                    cnt_reg[i] <= cnt_reg[i] + 1'b1;
                end
            end
        end
    end

    // Shadow of the array pipeline. It never stalls, because the array
    // cannot stall once it has accepted a read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_v_reg  <= '0;
            stage_id_reg <= '0;
        end else begin
            stage_v_reg[0]  <= fire_any;
            stage_id_reg[0] <= winner_id;
            for (int k = 1; k < LAT; k++) begin
                stage_v_reg[k]  <= stage_v_reg[k-1];
                stage_id_reg[k] <= stage_id_reg[k-1];
            end
        end
    end

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_resp
            assign resp_valid[gi] = stage_v_reg[LAT-1] &&
                                    (stage_id_reg[LAT-1] == IDW'(gi));
        end
    endgenerate

    assign busy = |stage_v_reg;

endmodule

// File: tb/tb_meta_read_arbiter.sv
module tb_meta_read_arbiter;

    localparam int NREQ  = 3;
    localparam int IDX_W = 6;
    localparam int TAG_W = 20;
    localparam int LAT   = 2;
    localparam int LIMIT = 8;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*IDX_W-1:0] req_idx = '0;
    logic [NREQ*TAG_W-1:0] req_tag = '0;
    logic                  arr_valid;
    logic                  arr_ready = 1'b0;
    logic [IDX_W-1:0]      arr_idx;
    logic [TAG_W-1:0]      arr_tag;
    logic [NREQ-1:0]       resp_valid;
    logic                  busy;

    meta_read_arbiter #(
        .NREQ(NREQ), .IDX_W(IDX_W), .TAG_W(TAG_W), .LAT(LAT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_tag(req_tag),
        .arr_valid(arr_valid), .arr_ready(arr_ready),
        .arr_idx(arr_idx), .arr_tag(arr_tag),
        .resp_valid(resp_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct { int id; int due; } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int waited [NREQ];
    logic [IDX_W-1:0] idx_a [NREQ];
    logic [TAG_W-1:0] tag_a [NREQ];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is due and checks
    // resp_valid / busy against what is outstanding.
    always @(negedge clock) begin
        logic [NREQ-1:0] exp_resp;
        if (!reset) begin
            chk("busy", 64'(busy), 64'(sb.size() > 0));
            exp_resp = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_resp[sb[0].id] = 1'b1;
                $display("[TB] cycle %0d response to requester %0d", cyc, sb[0].id);
                void'(sb.pop_front());
            end
            chk("resp_valid", 64'(resp_valid), 64'(exp_resp));
        end
    end

    // One cycle of stimulus plus the reference model's expected outputs.
    task automatic step(input logic [NREQ-1:0] v, input logic ar, input logic rs);
        int w;
        logic fire;
        logic [NREQ-1:0] er;
        @(posedge clock);
        #1;
        reset = rs;
        if (rs) begin
            sb.delete();
            for (int i = 0; i < NREQ; i++) waited[i] = 0;
        end
        req_valid = v;
        arr_ready = ar;
        for (int i = 0; i < NREQ; i++) begin
            idx_a[i] = IDX_W'($urandom);
            tag_a[i] = TAG_W'($urandom);
            req_idx[i*IDX_W +: IDX_W] = idx_a[i];
            req_tag[i*TAG_W +: TAG_W] = tag_a[i];
        end
        @(negedge clock);
        #1;
        if (rs) begin
            chk("rst_arr_valid", 64'(arr_valid), 64'd0);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
        end else begin
            // Any requester that has waited the limit outranks the fixed order.
            w = -1;
            for (int i = 0; i < NREQ; i++)
                if (w < 0 && v[i] && waited[i] == LIMIT) w = i;
            for (int i = 0; i < NREQ; i++)
                if (w < 0 && v[i]) w = i;
            fire = (w >= 0) && ar;
            er = '0;
            if (fire) er[w] = 1'b1;
            chk("arr_valid", 64'(arr_valid), 64'(w >= 0));
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("arr_idx", 64'(arr_idx), (w >= 0) ? 64'(idx_a[w]) : 64'd0);
            chk("arr_tag", 64'(arr_tag), (w >= 0) ? 64'(tag_a[w]) : 64'd0);
            if (fire) begin
                sb.push_back('{w, cyc + LAT});
                $display("[TB] cycle %0d grant requester %0d idx=%0h", cyc, w, idx_a[w]);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (fire && i == w)                 waited[i] = 0;
                else if (!v[i])                     waited[i] = 0;
                else if (ar && waited[i] < LIMIT)   waited[i] = waited[i] + 1;
            end
        end
    endtask

    initial begin
        int first_fire2;
        for (int i = 0; i < NREQ; i++) waited[i] = 0;

        // Reset held, then five idle cycles.
        for (int i = 0; i < 3; i++) step(3'b000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(3'b000, 1'b1, 1'b0);

        // All three request: requester 0 wins.
        step(3'b111, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);

        // Requester 2 starves behind requester 0 and is boosted on cycle 8.
        first_fire2 = -1;
        for (int j = 0; j < 12; j++) begin
            step(3'b101, 1'b1, 1'b0);
            if (first_fire2 < 0 && req_ready == 3'b100) first_fire2 = j;
        end
        chk("starve_fire_cycle", 64'(first_fire2), 64'd8);
        step(3'b000, 1'b1, 1'b0);

        // Back-pressure is not denial; requester 1 fires as soon as it lifts.
        for (int j = 0; j < 20; j++) step(3'b010, 1'b0, 1'b0);
        step(3'b010, 1'b1, 1'b0);

        // Back-to-back fires from mixed requesters.
        step(3'b010, 1'b1, 1'b0);
        step(3'b001, 1'b1, 1'b0);
        step(3'b100, 1'b1, 1'b0);
        step(3'b100, 1'b1, 1'b0);

        // Fire, then reset while the read is in flight: no response expected.
        step(3'b001, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b1);
        step(3'b111, 1'b1, 1'b1);
        for (int j = 0; j < 4; j++) step(3'b000, 1'b1, 1'b0);

        // Random traffic with requester 0 biased high to provoke boosts.
        for (int j = 0; j < 1500; j++) begin
            logic [NREQ-1:0] v;
            v[0] = ($urandom_range(0, 3) != 0);
            v[1] = ($urandom_range(0, 2) == 0);
            v[2] = ($urandom_range(0, 1) == 0);
            step(v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
        end
        for (int j = 0; j < LAT + 2; j++) step(3'b000, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
